// File: rtl/node_integrator.sv
// Time-step stage for the spring solver: owns committed node position/velocity,
// integrates the streamed per-node forces (semi-implicit Euler) and commits atomically.
module node_integrator #(
  parameter int NUM_NODES     = 8,
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16,
  parameter int FORCE_SIZE    = 16,
  parameter int MASS_SHIFT    = 2,
  parameter int DT_SHIFT      = 3,
  parameter int GRAVITY       = -4,
  parameter int FLOOR_Y       = 0
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            load_valid,
  input  logic signed [POSITION_SIZE-1:0] load_nodes      [2][NUM_NODES],
  input  logic signed [VELOCITY_SIZE-1:0] load_velocities [2][NUM_NODES],
  input  logic                            step_req,
  input  logic signed [FORCE_SIZE-1:0]    force_x,
  input  logic signed [FORCE_SIZE-1:0]    force_y,
  input  logic                            force_valid,
  input  logic                            force_done,
  output logic                            springs_start,
  output logic signed [POSITION_SIZE-1:0] nodes           [2][NUM_NODES],
  output logic signed [VELOCITY_SIZE-1:0] velocities      [2][NUM_NODES],
  output logic                            busy,
  output logic                            step_done,
  output logic                            step_error
);

  localparam int MAXA = (FORCE_SIZE > VELOCITY_SIZE) ? FORCE_SIZE : VELOCITY_SIZE;
  localparam int W    = ((MAXA > POSITION_SIZE) ? MAXA : POSITION_SIZE) + 2;
  localparam int CW   = $clog2(NUM_NODES + 1);
  localparam int IW   = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [CW-1:0]                   N_CNT   = CW'(NUM_NODES);
  localparam logic signed [W-1:0]             GRAV_W  = W'(GRAVITY);
  localparam logic signed [POSITION_SIZE-1:0] FLOOR_P = POSITION_SIZE'(FLOOR_Y);

  typedef enum logic [1:0] {IDLE, KICK, WAIT, COMMIT} state_t;

  state_t                          state, state_nx;
  logic [CW-1:0]                   cnt;
  logic [IW-1:0]                   idx;
  logic                            err_flag, err_pulse;
  logic                            take, overflow, done_ok, done_bad;
  logic [CW-1:0]                   cnt_after;
  logic signed [POSITION_SIZE-1:0] stg_p [2][NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] stg_v [2][NUM_NODES];
  logic signed [POSITION_SIZE-1:0] new_p [2];
  logic signed [VELOCITY_SIZE-1:0] new_v [2];

  function automatic logic signed [VELOCITY_SIZE-1:0] sat_v(input logic signed [W-1:0] x);
    logic signed [W-1:0] hi, lo;
    hi = W'((1 << (VELOCITY_SIZE - 1)) - 1);
    lo = ~hi;
    if (x > hi)      return hi[VELOCITY_SIZE-1:0];
    else if (x < lo) return lo[VELOCITY_SIZE-1:0];
    else             return x[VELOCITY_SIZE-1:0];
  endfunction

  function automatic logic signed [POSITION_SIZE-1:0] sat_p(input logic signed [W-1:0] x);
    logic signed [W-1:0] hi, lo;
    hi = W'((1 << (POSITION_SIZE - 1)) - 1);
    lo = ~hi;
    if (x > hi)      return hi[POSITION_SIZE-1:0];
    else if (x < lo) return lo[POSITION_SIZE-1:0];
    else             return x[POSITION_SIZE-1:0];
  endfunction

  function automatic logic signed [VELOCITY_SIZE-1:0] next_v(
    input logic signed [VELOCITY_SIZE-1:0] v,
    input logic signed [FORCE_SIZE-1:0]    f,
    input logic signed [W-1:0]             g
  );
    logic signed [W-1:0] vw, fw, a;
    vw = v;
    fw = f;
    a  = (fw >>> MASS_SHIFT) + g;
    return sat_v(vw + (a >>> DT_SHIFT));
  endfunction

  function automatic logic signed [POSITION_SIZE-1:0] next_p(
    input logic signed [POSITION_SIZE-1:0] p,
    input logic signed [VELOCITY_SIZE-1:0] nv
  );
    logic signed [W-1:0] pw, vw;
    pw = p;
    vw = nv;
    return sat_p(pw + (vw >>> DT_SHIFT));
  endfunction

  assign idx = cnt[IW-1:0];

  always_comb begin
    new_v[0] = next_v(velocities[0][idx], force_x, '0);
    new_p[0] = next_p(nodes[0][idx], new_v[0]);
    new_v[1] = next_v(velocities[1][idx], force_y, GRAV_W);
    new_p[1] = next_p(nodes[1][idx], new_v[1]);
    if (new_p[1] < FLOOR_P) begin
      new_p[1] = FLOOR_P;
      if (new_v[1][VELOCITY_SIZE-1]) new_v[1] = '0;
    end
  end

  always_comb begin
    take      = (state == WAIT) && force_valid && (cnt < N_CNT);
    overflow  = (state == WAIT) && force_valid && (cnt == N_CNT);
    cnt_after = take ? cnt + CW'(1) : cnt;
    done_ok   = (state == WAIT) && force_done && (cnt_after == N_CNT) && !err_flag && !overflow;
    done_bad  = (state == WAIT) && force_done && !done_ok;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!load_valid && step_req) state_nx = KICK;
      KICK:    state_nx = WAIT;
      WAIT:    if (done_ok) state_nx = COMMIT;
               else if (done_bad) state_nx = IDLE;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    springs_start = (state == KICK);
    step_done     = (state == COMMIT);
    busy          = (state != IDLE);
    step_error    = err_pulse;
  end

  // The commit copy happens on the WAIT->COMMIT edge (merging a same-cycle last
  // node) so the new state is already visible while step_done is high.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt       <= '0;
      err_flag  <= 1'b0;
      err_pulse <= 1'b0;
      for (int unsigned a = 0; a < 2; a++)
        for (int unsigned n = 0; n < NUM_NODES; n++) begin
          nodes[a][n]      <= '0;
          velocities[a][n] <= '0;
          stg_p[a][n]      <= '0;
          stg_v[a][n]      <= '0;
        end
    end else begin
      err_pulse <= done_bad;
      if (state == KICK) cnt <= '0;
      if (take) begin
        cnt <= cnt + CW'(1);
        for (int unsigned a = 0; a < 2; a++) begin
          stg_p[a][idx] <= new_p[a];
          stg_v[a][idx] <= new_v[a];
        end
      end
      if (overflow) err_flag <= 1'b1;
      if (done_bad) err_flag <= 1'b0;
      if (state == IDLE && load_valid)
        for (int unsigned a = 0; a < 2; a++)
          for (int unsigned n = 0; n < NUM_NODES; n++) begin
            nodes[a][n]      <= load_nodes[a][n];
            velocities[a][n] <= load_velocities[a][n];
          end
      if (done_ok)
        for (int unsigned a = 0; a < 2; a++)
          for (int unsigned n = 0; n < NUM_NODES; n++) begin
            nodes[a][n]      <= (take && idx == IW'(n)) ? new_p[a] : stg_p[a][n];
            velocities[a][n] <= (take && idx == IW'(n)) ? new_v[a] : stg_v[a][n];
          end
    end
  end

endmodule

// File: tb/tb_node_integrator.sv
// Scoreboard bench for node_integrator: directed steps push expected commit/abort
// results; monitors pop and compare on step_done/step_error.
module tb_node_integrator;
  localparam int N = 8;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in;
  logic load_valid, s_load_valid, step_req, s_step_req;
  logic force_valid, force_done;
  logic signed [15:0] force_x, force_y;
  logic signed [15:0] load_nodes [2][N];
  logic signed [15:0] load_velocities [2][N];

  logic springs_start, busy, step_done, step_error;
  logic signed [15:0] nodes [2][N];
  logic signed [15:0] velocities [2][N];
  logic s_springs_start, s_busy, s_step_done, s_step_error;
  logic signed [15:0] s_nodes [2][N];
  logic signed [15:0] s_velocities [2][N];

  node_integrator u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .load_valid(load_valid),
    .load_nodes(load_nodes), .load_velocities(load_velocities),
    .step_req(step_req), .force_x(force_x), .force_y(force_y),
    .force_valid(force_valid), .force_done(force_done),
    .springs_start(springs_start), .nodes(nodes), .velocities(velocities),
    .busy(busy), .step_done(step_done), .step_error(step_error)
  );

  node_integrator #(.MASS_SHIFT(0), .DT_SHIFT(0)) u_sat (
    .clk_in(clk_in), .rst_in(rst_in), .load_valid(s_load_valid),
    .load_nodes(load_nodes), .load_velocities(load_velocities),
    .step_req(s_step_req), .force_x(force_x), .force_y(force_y),
    .force_valid(force_valid), .force_done(force_done),
    .springs_start(s_springs_start), .nodes(s_nodes), .velocities(s_velocities),
    .busy(s_busy), .step_done(s_step_done), .step_error(s_step_error)
  );

  typedef struct packed {
    logic         is_err;
    logic [255:0] p;
    logic [255:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t sat_q[$];
  exp_t me, se;
  int tests = 0, fails = 0;
  int cyc = 0, fd_cyc = 0, kicks = 0, s_kicks = 0;
  logic signed [15:0] e_p [2][N];
  logic signed [15:0] e_v [2][N];
  logic signed [15:0] fx [N];
  logic signed [15:0] fy [N];

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [255:0] flat(input logic signed [15:0] a [2][N]);
    logic [255:0] r;
    r = '0;
    for (int ax = 0; ax < 2; ax++)
      for (int n = 0; n < N; n++) r[(ax*N+n)*16 +: 16] = a[ax][n];
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk_in) if (!rst_in) begin
    if (springs_start) kicks++;
    if (step_done || step_error) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_event: got done=%0b err=%0b expected none", step_done, step_error);
      end else begin
        me = exp_q.pop_front();
        check("kind", {step_error, step_done}, me.is_err ? 2'b10 : 2'b01);
        check("latency", cyc - fd_cyc, 1);
        check("kicks", kicks, 1);
        check("nodes", flat(nodes), me.p);
        check("velocities", flat(velocities), me.v);
        kicks = 0;
      end
    end
  end

  always @(negedge clk_in) if (!rst_in) begin
    if (s_springs_start) s_kicks++;
    if (s_step_done || s_step_error) begin
      if (sat_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sat_unexpected_event: got done=%0b err=%0b expected none", s_step_done, s_step_error);
      end else begin
        se = sat_q.pop_front();
        check("sat_kind", {s_step_error, s_step_done}, se.is_err ? 2'b10 : 2'b01);
        check("sat_kicks", s_kicks, 1);
        check("sat_nodes", flat(s_nodes), se.p);
        check("sat_velocities", flat(s_velocities), se.v);
        s_kicks = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_load_all(input int px, py, vx, vy);
    for (int n = 0; n < N; n++) begin
      load_nodes[0][n] = 16'(px); load_nodes[1][n] = 16'(py);
      load_velocities[0][n] = 16'(vx); load_velocities[1][n] = 16'(vy);
    end
  endtask

  task automatic set_exp_all(input int px, py, vx, vy);
    for (int n = 0; n < N; n++) begin
      e_p[0][n] = 16'(px); e_p[1][n] = 16'(py);
      e_v[0][n] = 16'(vx); e_v[1][n] = 16'(vy);
    end
  endtask

  task automatic set_exp_node(input int n, px, py, vx, vy);
    e_p[0][n] = 16'(px); e_p[1][n] = 16'(py);
    e_v[0][n] = 16'(vx); e_v[1][n] = 16'(vy);
  endtask

  task automatic zero_forces();
    for (int n = 0; n < N; n++) begin fx[n] = '0; fy[n] = '0; end
  endtask

  task automatic push_exp(input bit sat, input bit is_err);
    exp_t e;
    e.is_err = is_err;
    e.p = flat(e_p);
    e.v = flat(e_v);
    if (sat) sat_q.push_back(e);
    else     exp_q.push_back(e);
  endtask

  task automatic do_load(input bit sat);
    if (sat) s_load_valid = 1'b1; else load_valid = 1'b1;
    tick();
    load_valid = 1'b0; s_load_valid = 1'b0;
  endtask

  task automatic run_step(input bit sat, input int nf, input bit merge_last, input bit load_mid);
    if (sat) s_step_req = 1'b1; else step_req = 1'b1;
    tick();
    step_req = 1'b0; s_step_req = 1'b0;
    tick();
    for (int i = 0; i < nf; i++) begin
      force_valid = 1'b1;
      force_x = (i < N) ? fx[i] : 16'sd0;
      force_y = (i < N) ? fy[i] : 16'sd0;
      if (merge_last && i == nf - 1) begin force_done = 1'b1; fd_cyc = cyc; end
      if (load_mid && i == 2) load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
    end
    force_valid = 1'b0; force_x = '0; force_y = '0;
    if (!merge_last) begin force_done = 1'b1; fd_cyc = cyc; tick(); end
    force_done = 1'b0;
    tick(); tick();
  endtask

  task automatic check_all_zero(input string tag);
    logic [255:0] z;
    z = '0;
    check({tag, "_nodes"}, flat(nodes), z);
    check({tag, "_vels"}, flat(velocities), z);
    check({tag, "_flags"}, {springs_start, busy, step_done, step_error,
                            s_springs_start, s_busy, s_step_done, s_step_error}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    load_valid = 1'b0; s_load_valid = 1'b0; step_req = 1'b0; s_step_req = 1'b0;
    force_valid = 1'b0; force_done = 1'b0; force_x = '0; force_y = '0;
    set_load_all(0, 0, 0, 0);
    zero_forces();
    repeat (2) @(negedge clk_in);
    check_all_zero("reset");
    tick();
    rst_in = 1'b0;
    tick();

    // uniform drop under gravity, separate done
    set_load_all(0, 800, 0, 0);
    do_load(1'b0);
    set_exp_all(0, 799, 0, -1);
    push_exp(1'b0, 1'b0);
    run_step(1'b0, 8, 1'b0, 1'b0);

    // mixed: forced node 3, floor node 5, done coincides with 8th force
    set_load_all(0, 800, 0, 0);
    load_nodes[0][3] = 16'sd100;
    load_nodes[0][5] = 16'sd50; load_nodes[1][5] = 16'sd0; load_velocities[1][5] = -16'sd40;
    do_load(1'b0);
    fx[3] = 16'sd64; fy[3] = 16'sd32;
    set_exp_all(0, 799, 0, -1);
    set_exp_node(3, 100, 800, 2, 0);
    set_exp_node(5, 50, 0, 0, 0);
    push_exp(1'b0, 1'b0);
    run_step(1'b0, 8, 1'b1, 1'b0);
    zero_forces();

    // short and long streams abort without commit
    push_exp(1'b0, 1'b1);
    run_step(1'b0, 5, 1'b0, 1'b0);
    push_exp(1'b0, 1'b1);
    run_step(1'b0, 9, 1'b0, 1'b0);

    // load_valid during WAIT must be ignored
    set_load_all(1234, 1234, 1234, 1234);
    set_exp_all(0, 798, 0, -2);
    set_exp_node(3, 100, 799, 2, -1);
    set_exp_node(5, 50, 0, 0, 0);
    push_exp(1'b0, 1'b0);
    run_step(1'b0, 8, 1'b0, 1'b1);

    // saturation on the MASS_SHIFT=0 / DT_SHIFT=0 instance
    set_load_all(0, 800, 0, 0);
    load_nodes[0][0] = 16'sd100;  load_velocities[0][0] = 16'sd32760;
    load_nodes[0][1] = -16'sd100; load_velocities[0][1] = -16'sd32760;
    do_load(1'b1);
    fx[0] = 16'sd32767; fx[1] = -16'sd32768;
    set_exp_all(0, 796, 0, -4);
    set_exp_node(0, 32767, 796, 32767, -4);
    set_exp_node(1, -32768, 796, -32768, -4);
    push_exp(1'b1, 1'b0);
    run_step(1'b1, 8, 1'b0, 1'b0);
    zero_forces();

    // asynchronous reset in the middle of WAIT
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    force_valid = 1'b1;
    repeat (3) tick();
    #2 rst_in = 1'b1;
    #1 check_all_zero("rst_async");
    force_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check_all_zero("rst_hold");
    end
    tick();
    rst_in = 1'b0;
    kicks = 0; s_kicks = 0;
    repeat (4) tick();
    check("rst_idle_busy", {busy, s_busy}, 2'b00);
    check("queues_drained", exp_q.size() + sat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
